reaction_delay_timer: RTL
=========================

# reaction_delay_timer

Consumer of the 12-bit pseudo-random word from the game's LFSR stage. On each round start it samples the random word, waits a random foreperiod of `MIN_DELAY_MS + rnd` milliseconds, lights the stimulus LED, then measures the player's reaction time in milliseconds. It detects false starts (a press before the LED) and presents the result to the display stage.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clock cycles per millisecond tick (50 MHz clock); must be ≥ 2.
- `MIN_DELAY_MS`, default 1000: fixed part of the foreperiod, in ms.
- `RT_MAX`, default 9999: reaction-count saturation value, in ms (4-digit display).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `cin`, input, 1: system clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous active-high reset.
- `start`, input, 1: round-start request, level sampled each cycle.
- `btn`, input, 1: player button, already synchronised and debounced, active-high.
- `rnd`, input, 12: random word from the LFSR, sampled only on round start.
- `led`, output, 1: stimulus LED.
- `busy`, output, 1: high in WAIT and ARMED.
- `done`, output, 1: high in DONE.
- `foul`, output, 1: high in FOUL.
- `rt_ms`, output, 14: measured reaction time in ms, held until the next round start.
- `rt_valid`, output, 1: one-cycle pulse when `rt_ms` is updated.

## Operation
- States: IDLE, WAIT, ARMED, DONE, FOUL.
- Internal registers:
  - `btn_q`: `btn` delayed one cycle.
  - `edge = btn & ~btn_q`.
  - Prescaler `ps` (0..TICK_DIV-1).
  - Delay counter `dcnt`, 13 bits.
  - Reaction counter `rcnt`, 14 bits.
- **IDLE / DONE / FOUL, `start`=1:**
  - `dcnt` ← `MIN_DELAY_MS + rnd` (zero-extended; no overflow at defaults).
  - `ps` ← 0; go to WAIT.
  - `foul` and `done` clear on that edge.
  - `rt_ms` is held until it is overwritten.
- **WAIT, each cycle:**
  - If `ps` = TICK_DIV-1: `ps` ← 0, then if `dcnt` = 1 go to ARMED, else decrement `dcnt`.
  - Otherwise `ps` increments.
- **WAIT, `edge`=1:** go to FOUL (false start).
  - Takes priority over the tick on the same cycle.
  - `led` never rises; `rt_valid` does not pulse; `rt_ms` is unchanged.
- **ARMED entry:** `led`=1, `rcnt`=0, `ps`=0.
  - Each tick (`ps` wrap) increments `rcnt`, saturating at `RT_MAX`.
- **ARMED, `edge`=1:** go to DONE.
  - `rt_ms` ← current `rcnt` (value before any same-cycle increment).
  - `rt_valid` pulses; `led` ← 0.
- **ARMED, `rcnt` = `RT_MAX` with no edge:** go to DONE.
  - `rt_ms` ← `RT_MAX`; `rt_valid` pulses.
  - If an edge arrives on the same cycle, the edge path applies (same value).
- **Ignored inputs:**
  - `start` is ignored in WAIT and ARMED.
  - `edge` is ignored in IDLE, DONE and FOUL.
  - A button held high across ARMED entry produces no edge; the player must release and press again.

## Timing
- **Reset** (edge with `rst`=1):
  - State IDLE.
  - `led`, `busy`, `done`, `foul`, `rt_valid` = 0; `rt_ms` = 0.
  - `ps`, `dcnt`, `rcnt` = 0; `btn_q` = 0.
  - Reset overrides every other input, including mid-round.
- **Outputs:** all are registered. Outputs reflect the state entered on the same edge.
- **Foreperiod:** with `start` sampled at edge k, WAIT is entered at edge k. `led` rises at edge k + D·TICK_DIV, where D = `MIN_DELAY_MS + rnd`.
- **Press detection:** `btn` rises before edge m, so `edge` is high during cycle m..m+1. DONE, `rt_valid` and `led`=0 take effect at edge m+1.
- **Reaction count:** `rt_ms` = number of completed ticks between ARMED entry and the edge-detect cycle.
- **Minimum gap:** one cycle between DONE/FOUL and a new WAIT.

## Test plan
TICK_DIV=4, MIN_DELAY_MS=2, RT_MAX=9999.

1. Assert `rst` with `start`=1 and `btn`=1 → after the edge, every output is 0 and the block stays in IDLE while `rst`=1.
2. `start` pulse with `rnd`=3 → `busy`=1 at the next edge; `led` rises exactly 20 cycles after WAIT entry. Repeat with `rnd`=0 → 8 cycles.
3. Press `btn` 42 cycles after `led` rises → `rt_ms`=10, `rt_valid` high for exactly one cycle, `done`=1, `led`=0, `busy`=0.
4. Press during WAIT → `foul`=1 one edge later, `led` stays 0 for ≥100 cycles, `rt_ms` keeps its previous value, no `rt_valid` pulse. A later `start` clears `foul` and begins a new WAIT.
5. No press in ARMED → `rt_ms`=9999 and `rt_valid` after 9999×4 cycles. `btn` held high across ARMED entry gives no result until release and re-press. `start` pulses during WAIT/ARMED have no effect.
6. Assert `rst` in the middle of ARMED (`led`=1) → `led`, `busy`, `rt_ms` = 0 at the next edge. A following `start` runs a complete, correct round.

Source files
------------

// File: rtl/reaction_delay_timer.sv
// Reaction-time game core: random foreperiod from the LFSR word, stimulus LED,
// millisecond reaction count with false-start detection and saturation.
module reaction_delay_timer #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RT_MAX       = 9999
) (
  input  logic        cin,
  input  logic        rst,
  input  logic        start,
  input  logic        btn,
  input  logic [11:0] rnd,
  output logic        led,
  output logic        busy,
  output logic        done,
  output logic        foul,
  output logic [13:0] rt_ms,
  output logic        rt_valid
);

  localparam int unsigned PsW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PsW-1:0] PsLast   = PsW'(TICK_DIV - 1);
  localparam logic [13:0]    RtMax    = 14'(RT_MAX);
  localparam logic [12:0]    MinDelay = 13'(MIN_DELAY_MS);

  typedef enum logic [2:0] {StIdle, StWait, StArmed, StDone, StFoul} state_e;

  state_e         state;
  logic [PsW-1:0] ps;
  logic [12:0]    dcnt;
  logic [13:0]    rcnt;
  logic           btn_q;
  logic           btn_edge;
  logic           tick;

  assign btn_edge = btn & ~btn_q;
  assign tick     = (ps == PsLast);

  always_ff @(posedge cin) begin
    if (rst) begin
      state    <= StIdle;
      ps       <= '0;
      dcnt     <= '0;
      rcnt     <= '0;
      btn_q    <= 1'b0;
      led      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      foul     <= 1'b0;
      rt_ms    <= '0;
      rt_valid <= 1'b0;
    end else begin
      btn_q    <= btn;
      rt_valid <= 1'b0;
      unique case (state)
        StIdle, StDone, StFoul: begin
          if (start) begin
            dcnt  <= MinDelay + 13'(rnd);
            ps    <= '0;
            state <= StWait;
            busy  <= 1'b1;
            done  <= 1'b0;
            foul  <= 1'b0;
          end
        end
        StWait: begin
          // A false start beats a tick that would arm on the same cycle.
          if (btn_edge) begin
            state <= StFoul;
            busy  <= 1'b0;
            foul  <= 1'b1;
          end else if (tick) begin
            ps <= '0;
            if (dcnt <= 13'd1) begin
              state <= StArmed;
              led   <= 1'b1;
              rcnt  <= '0;
            end else begin
              dcnt <= dcnt - 13'd1;
            end
          end else begin
            ps <= ps + PsW'(1);
          end
        end
        StArmed: begin
          // Result is the count before any same-cycle tick; saturation ends the round.
          if (btn_edge || (rcnt == RtMax)) begin
            state    <= StDone;
            rt_ms    <= rcnt;
            rt_valid <= 1'b1;
            led      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (tick) begin
            ps   <= '0;
            rcnt <= rcnt + 14'd1;
          end else begin
            ps <= ps + PsW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
